// File: rtl/waveform_pkg.sv
// waveform_pkg: shared constants and the sample-to-row mapping for the scrolling waveform renderer
package waveform_pkg;
    localparam int PIPE_LAT = 3;
    localparam int PIX_W    = 12;
    localparam int SAMPLE_W = 8;
    // Row for an 8-bit sample: BOTTOM - (((BOTTOM-TOP)*s) >> 8), 19-bit product, 11-bit result
    function automatic logic [10:0] y_map(input logic [7:0] s, input logic [10:0] top, input logic [10:0] bottom);
        logic [18:0] p;
        p = 19'(bottom - top) * 19'(s);
        return bottom - p[18:8];
    endfunction
endpackage

// File: rtl/waveform_sample_ram.sv
// waveform_sample_ram: simple dual-port sample history RAM (one write port, one registered read port)
//   clk  - clock
//   we   - write enable, wa/wd write address/data
//   ra   - read address, rd read data one clk later
module waveform_sample_ram #(
    parameter int DEPTH = 1024,
    parameter int DW    = 16,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);
    logic [DW-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        rd <= mem[ra];
    end
endmodule

// File: rtl/waveform_scroll.sv
// waveform_scroll: multi-channel scrolling waveform renderer for the VGA pixel path
//   clk, reset        - pixel clock, synchronous active-high reset
//   hcount, vcount    - current pixel column/row
//   sample_in         - 8 bits per channel, channel k at [8k+7:8k]; sample_valid strobes a write
//   freeze            - blocks writes so the display holds
//   colors            - RGB444 per channel, channel k at [12k+11:12k]
//   enable            - forces pixel to 0 when low
//   full              - WIDTH samples have been written
//   pixel             - rendered color, 3 clk after hcount/vcount
// Define WAVEFORM_SCROLL_LINE_EN for connected-line mode; default is dot mode.
module waveform_scroll
    import waveform_pkg::*;
#(
    parameter int CHANNELS  = 2,
    parameter int WIDTH     = 1024,
    parameter int TOP       = 0,
    parameter int BOTTOM    = 768,
    parameter int THICKNESS = 3,
    parameter int X_BEGIN   = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [10:0]                  hcount,
    input  logic [9:0]                   vcount,
    input  logic [SAMPLE_W*CHANNELS-1:0] sample_in,
    input  logic                         sample_valid,
    input  logic                         freeze,
    input  logic [PIX_W*CHANNELS-1:0]    colors,
    input  logic                         enable,
    output logic                         full,
    output logic [PIX_W-1:0]             pixel
);
    localparam int AW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam int DW = SAMPLE_W * CHANNELS;

    logic [AW-1:0] wr_ptr, base, base_e, ra;
    logic [11:0]   fill, fill_s, fill_e, col, sum;
    logic          we, snap, in_rng, col_ok, v1, v2;
    logic [9:0]    vc1, vc2;
    logic [DW-1:0] rd;
    logic [10:0]   y_cur [CHANNELS];
    logic [10:0]   y2 [CHANNELS];
`ifdef WAVEFORM_SCROLL_LINE_EN
    logic [10:0]   yp2 [CHANNELS];
`endif
    logic [PIX_W-1:0] pix_n;

    assign we   = sample_valid && !freeze && !reset;
    assign snap = hcount == '0 && vcount == '0;
    assign full = fill == 12'(WIDTH);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            fill   <= '0;
            base   <= '0;
            fill_s <= '0;
        end else begin
            if (snap) begin
                base   <= wr_ptr;
                fill_s <= fill;
            end
            if (we) begin
                wr_ptr <= wr_ptr == AW'(WIDTH - 1) ? '0 : wr_ptr + AW'(1);
                fill   <= full ? fill : fill + 12'd1;
            end
        end
    end

    // The snapshot is bypassed into the read so column 0 of the new frame already uses it
    always_comb begin
        base_e = snap ? wr_ptr : base;
        fill_e = snap ? fill : fill_s;
        col    = 12'(hcount) - 12'(X_BEGIN);
        in_rng = 12'(hcount) >= 12'(X_BEGIN) && col < 12'(WIDTH);
        col_ok = col >= 12'(WIDTH) - fill_e;
        sum    = 12'(base_e) + col;
        ra     = sum >= 12'(WIDTH) ? AW'(sum - 12'(WIDTH)) : AW'(sum);
    end

    waveform_sample_ram #(.DEPTH(WIDTH), .DW(DW), .AW(AW)) u_ram (
        .clk(clk),
        .we(we),
        .wa(wr_ptr),
        .wd(sample_in),
        .ra(ra),
        .rd(rd)
    );

    always_comb begin
        for (int k = 0; k < CHANNELS; k++) y_cur[k] = y_map(rd[SAMPLE_W*k +: SAMPLE_W], 11'(TOP), 11'(BOTTOM));
    end

    always_ff @(posedge clk) begin
        vc1 <= vcount;
        vc2 <= vc1;
        for (int k = 0; k < CHANNELS; k++) begin
            y2[k] <= y_cur[k];
`ifdef WAVEFORM_SCROLL_LINE_EN
            // First valid column has no predecessor, so it joins to itself
            yp2[k] <= v2 ? y2[k] : y_cur[k];
`endif
        end
    end

    // Descending scan lets the lowest channel index win overlaps
    always_comb begin
        logic [10:0] lo, hi;
        lo    = '0;
        hi    = '0;
        pix_n = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
`ifdef WAVEFORM_SCROLL_LINE_EN
            lo = yp2[k] < y2[k] ? yp2[k] : y2[k];
            hi = yp2[k] < y2[k] ? y2[k] : yp2[k];
`else
            lo = y2[k];
            hi = y2[k];
`endif
            if ({1'b0, vc2} >= lo && 12'(vc2) < 12'(hi) + 12'(THICKNESS)) pix_n = colors[PIX_W*k +: PIX_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            pixel <= '0;
        end else begin
            v1    <= in_rng && col_ok;
            v2    <= v1;
            pixel <= enable && v2 ? pix_n : '0;
        end
    end
endmodule
